// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: three requesters in, one register-file write out.
// master = requesters + register file side, slave = arbiter side.
interface wb_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [2:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [ADDR_W-1:0] req_addr2;
  logic [WIDTH-1:0]  req_data0;
  logic [WIDTH-1:0]  req_data1;
  logic [WIDTH-1:0]  req_data2;
  logic [2:0]        req_ready;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [1:0]        grant_id;
  logic [15:0]       coll_cnt;

  modport master (
    output req_valid, req_addr0, req_addr1, req_addr2,
    output req_data0, req_data1, req_data2, wr_stall,
    input  req_ready, wr_en, wr_addr, wr_data,
    input  grant_id, coll_cnt
  );

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_addr2,
    input  req_data0, req_data1, req_data2, wr_stall,
    output req_ready, wr_en, wr_addr, wr_data,
    output grant_id, coll_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: ALU/MEM/MUL (bit 0/1/2) share one regfile write port.
// Ports: clk, rst_n (async low), bus (slave). Round-robin by default;
// define WB_ARB_FIXED_PRIO_EN for fixed priority ALU > MEM > MUL.
module wb_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_port_arbiter_if.slave bus
);

  logic [2:0]        vld;
  logic [2:0]        gnt;
  logic [2:0]        rdy;
  logic              xfer;
  logic              stall;
  logic              multi;
  logic [1:0]        sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;

  logic              en_q,   en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [1:0]        id_q,   id_d;
  logic [15:0]       coll_q, coll_d;

  assign vld   = bus.req_valid;
  assign stall = bus.wr_stall;

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    priority case (1'b1)
      vld[0]:  gnt = 3'b001;
      vld[1]:  gnt = 3'b010;
      vld[2]:  gnt = 3'b100;
      default: gnt = '0;
    endcase
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] ptr_eff;
  logic [2:0] rot;
  logic [2:0] oh;

  // Out-of-range pointer falls back to ALU-first.
  assign ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

  // Rotate so the pointer slot is bit 0, take the lowest set bit,
  // then rotate the one-hot back into requester order.
  always_comb begin
    rot = vld;
    gnt = '0;
    unique case (ptr_eff)
      2'd1:    rot = {vld[0], vld[2], vld[1]};
      2'd2:    rot = {vld[1], vld[0], vld[2]};
      default: rot = vld;
    endcase
    oh = rot & (~rot + 3'd1);
    unique case (ptr_eff)
      2'd1:    gnt = {oh[1], oh[0], oh[2]};
      2'd2:    gnt = {oh[0], oh[2], oh[1]};
      default: gnt = oh;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      unique case (1'b1)
        rdy[0]:  ptr_d = 2'd1;
        rdy[1]:  ptr_d = 2'd2;
        default: ptr_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign rdy  = (stall || !rst_n) ? 3'b000 : gnt;
  assign xfer = |rdy;

  always_comb begin
    sel_id   = 2'd0;
    sel_addr = bus.req_addr0;
    sel_data = bus.req_data0;
    unique case (1'b1)
      gnt[1]: begin
        sel_id   = 2'd1;
        sel_addr = bus.req_addr1;
        sel_data = bus.req_data1;
      end
      gnt[2]: begin
        sel_id   = 2'd2;
        sel_addr = bus.req_addr2;
        sel_data = bus.req_data2;
      end
      default: ;
    endcase
  end

  assign multi = (vld[0] & vld[1]) | (vld[0] & vld[2]) | (vld[1] & vld[2]);

  always_comb begin
    en_d   = en_q;
    addr_d = addr_q;
    data_d = data_q;
    id_d   = id_q;
    coll_d = coll_q;
    if (!stall) begin
      // x0 writes are accepted but never reach the register file.
      en_d = xfer && (sel_addr != '0);
      if (xfer) begin
        addr_d = sel_addr;
        data_d = sel_data;
        id_d   = sel_id;
      end
      if (multi && (coll_q != 16'hFFFF)) coll_d = coll_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      id_q   <= '0;
      coll_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      id_q   <= id_d;
      coll_q <= coll_d;
    end
  end

  assign bus.req_ready = rdy;
  assign bus.wr_en     = en_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.grant_id  = id_q;
  assign bus.coll_cnt  = coll_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 32, the data width of each requester and of the write port.
- REQ-002: The block SHALL have parameter ADDR_W, default 5, the register address width.
- REQ-003: Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004: Port rst_n, input, 1: asynchronous, active-low reset.
- REQ-005: Ports req_valid, input, 3: per-requester write request (bit 0 ALU, bit 1 MEM, bit 2 MUL).
- REQ-006: Ports req_addr0/1/2, input, ADDR_W each: destination register per requester.
- REQ-007: Ports req_data0/1/2, input, WIDTH each: write data per requester.
- REQ-008: Port req_ready, output, 3: per-requester accept; combinational.
- REQ-009: Port wr_stall, input, 1: register file cannot accept a write this cycle.
- REQ-010: Port wr_en, output, 1: registered write enable to the register file.
- REQ-011: Port wr_addr, output, ADDR_W: registered write address.
- REQ-012: Port wr_data, output, WIDTH: registered write data.
- REQ-013: Port grant_id, output, 2: registered index of the last accepted requester.
- REQ-014: Port coll_cnt, output, 16: saturating count of cycles with two or more valid requests while not stalled.

Function
- REQ-015: A transfer for requester i SHALL occur when req_valid[i] and req_ready[i] are both high at a rising clk.
- REQ-016: At most one req_ready bit SHALL be high in any cycle.
- REQ-017: req_ready SHALL be all-zero whenever wr_stall is high.
- REQ-018: When wr_stall is high, wr_en, wr_addr, wr_data, grant_id and the priority pointer SHALL hold their values.
- REQ-019: Round-robin mode:
  - A 2-bit priority pointer names the highest-priority requester.
  - Search order is ptr, ptr+1, ptr+2 (mod 3).
  - The first valid requester in that order is granted.
- REQ-020: After a transfer by requester i, the pointer SHALL become (i+1) mod 3; with no transfer the pointer SHALL be unchanged.
- REQ-021: A transfer in cycle n SHALL produce, at cycle n+1:
  - wr_addr and wr_data equal to the granted requester's inputs;
  - grant_id equal to i;
  - wr_en high, unless the address is 0.
- REQ-022: A transfer to address 0 SHALL be accepted (ready high) but SHALL drive wr_en low; wr_addr, wr_data and grant_id still update.
- REQ-023: In a non-stalled cycle with no transfer, wr_en SHALL go low at the next edge; wr_addr, wr_data and grant_id SHALL hold.
- REQ-024: Back-to-back transfers SHALL be supported every cycle; throughput is one write per cycle.
- REQ-025: coll_cnt SHALL increment by 1 in each non-stalled cycle with two or more req_valid bits high, and SHALL saturate at 16'hFFFF.
- REQ-026: Pointer values other than 0–2 SHALL be unreachable; if one occurs, the arbiter SHALL treat it as 0.

Reset
- REQ-027: While rst_n is low, the following SHALL be 0 immediately, independent of clk: wr_en, wr_addr, wr_data, grant_id, coll_cnt and the pointer.
- REQ-028: While rst_n is low, req_ready SHALL be 000.
- REQ-029: A request presented in the cycle reset is asserted mid-operation SHALL be lost; requesters re-present it after reset.
- REQ-030: The first grant after reset deassertion SHALL follow pointer = 0.

Configuration
- REQ-031: Macro WB_ARB_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority ALU > MEM > MUL; the pointer is not implemented and REQ-019/020 do not apply.
- REQ-032: Without WB_ARB_FIXED_PRIO_EN, round-robin per REQ-019/020 SHALL be used; all other requirements apply in both builds.

Verification
- REQ-033: Reset, then req_valid=111 for 3 cycles with addrs 1/2/3 and data A/B/C (round-robin build) -> wr_addr sequence 1,2,3; grant_id 0,1,2; wr_en=1 each; coll_cnt=3.
- REQ-034: Same stimulus in the WB_ARB_FIXED_PRIO_EN build -> ALU granted all 3 cycles; wr_addr=1, grant_id=0 throughout.
- REQ-035: MEM valid with addr 7, data 32'hDEADBEEF, wr_stall=1 for 2 cycles then 0 -> req_ready=000 while stalled, outputs held; wr_en=1, wr_addr=7 one cycle after stall drops.
- REQ-036: MUL valid with addr 0, data 32'h1234 -> req_ready[2]=1; next cycle wr_en=0, grant_id=2, wr_data=32'h1234.
- REQ-037: Transfer in progress, rst_n pulsed low between clock edges -> wr_en, coll_cnt and grant_id become 0 at once; next grant with req_valid=110 goes to MEM (pointer 0, ALU idle).
- REQ-038: Preload coll_cnt near 16'hFFFF (force), then hold req_valid=011 for 5 cycles -> coll_cnt stays 16'hFFFF.
